// File: rtl/cape_gpio_irq_pkg.sv
// Shared constants for the cape GPIO interrupt block: channel widths and
// APB register byte offsets.
package cape_gpio_irq_pkg;

  localparam int N_IN  = 28;
  localparam int N_IRQ = 24;

  localparam logic [7:0] CAPE_IRQ_IN      = 8'h00;
  localparam logic [7:0] CAPE_IRQ_RISE_EN = 8'h04;
  localparam logic [7:0] CAPE_IRQ_FALL_EN = 8'h08;
  localparam logic [7:0] CAPE_IRQ_DEB_EN  = 8'h0C;
  localparam logic [7:0] CAPE_IRQ_STATUS  = 8'h10;
  localparam logic [7:0] CAPE_IRQ_MASK    = 8'h14;
  localparam logic [7:0] CAPE_IRQ_DEB_DIV = 8'h18;

endpackage

// File: rtl/cape_debounce.sv
// One GPIO input channel: 2-flop synchroniser followed by a tick-driven
// debouncer that holds the stable level of the pin.
module cape_debounce #(
  parameter int DEB_CNT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_in,
  input  logic tick,
  input  logic deb_en,
  output logic stable,
  output logic stable_nxt
);

  localparam logic [3:0] CNT_LAST = 4'(DEB_CNT - 1);

  logic       meta_q, meta_d;
  logic       sync_q, sync_d;
  logic       stable_q, stable_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= 4'd0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  // The counter only runs on ticks where sync disagrees with stable; the
  // tick that finds it already at CNT_LAST commits the new level.
  always_comb begin
    meta_d   = pin_in;
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (!deb_en) begin
      stable_d = sync_q;
      cnt_d    = 4'd0;
    end else if (tick) begin
      if (sync_q == stable_q) begin
        cnt_d = 4'd0;
      end else if (cnt_q == CNT_LAST) begin
        stable_d = sync_q;
        cnt_d    = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  assign stable     = stable_q;
  assign stable_nxt = stable_d;

endmodule

// File: rtl/cape_gpio_irq.sv
// Cape GPIO input-event block: per-pin conditioning, edge capture into a
// W1C status register, masked level interrupts, and an APB register file.
module cape_gpio_irq
  import cape_gpio_irq_pkg::*;
#(
  parameter logic [15:0] DEB_DIV_RST = 16'd1000,
  parameter int          DEB_CNT     = 3
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        APB_SLAVE_SLAVE_PSEL,
  input  logic        APB_SLAVE_SLAVE_PENABLE,
  input  logic        APB_SLAVE_SLAVE_PWRITE,
  input  logic [7:0]  APB_SLAVE_SLAVE_PADDR,
  input  logic [31:0] APB_SLAVE_SLAVE_PWDATA,
  output logic [31:0] APB_SLAVE_SLAVE_PRDATA,
  input  logic [27:0] GPIO_IN,
  output logic [7:0]  INT_A,
  output logic [7:0]  INT_B,
  output logic [7:0]  INT_C
);

  logic [N_IRQ-1:0] rise_en_q, rise_en_d;
  logic [N_IRQ-1:0] fall_en_q, fall_en_d;
  logic [N_IN-1:0]  deb_en_q, deb_en_d;
  logic [N_IRQ-1:0] status_q, status_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [15:0]      deb_div_q, deb_div_d;
  logic [15:0]      presc_q, presc_d;

  logic [N_IN-1:0]  stable_vec;
  logic [N_IN-1:0]  stable_nxt_vec;
  logic [N_IRQ-1:0] rise_ev, fall_ev, set_ev, w1c_bits;
  logic [7:0]       reg_addr;
  logic             wr_en;
  logic             tick;
  logic [15:0]      div_last;
  logic             unused_bits;

  assign wr_en    = APB_SLAVE_SLAVE_PSEL & APB_SLAVE_SLAVE_PENABLE & APB_SLAVE_SLAVE_PWRITE;
  assign reg_addr = {APB_SLAVE_SLAVE_PADDR[7:2], 2'b00};

  // Upper pins are IN-only, so their next-stable value feeds nothing.
  assign unused_bits = ^{APB_SLAVE_SLAVE_PADDR[1:0], APB_SLAVE_SLAVE_PWDATA[31:28],
                         stable_nxt_vec[N_IN-1:N_IRQ]};

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_deb
      cape_debounce #(.DEB_CNT(DEB_CNT)) u_deb (
        .clk       (PCLK),
        .rst_n     (PRESETN),
        .pin_in    (GPIO_IN[gi]),
        .tick      (tick),
        .deb_en    (deb_en_q[gi]),
        .stable    (stable_vec[gi]),
        .stable_nxt(stable_nxt_vec[gi])
      );
    end
  endgenerate

  // A divider of 0 is treated as 1, giving a tick every cycle.
  assign div_last = (deb_div_q == 16'd0) ? 16'd0 : deb_div_q - 16'd1;
  assign tick     = (presc_q >= div_last);

  // Edges are taken against the stable bit's next value so status lands on
  // the same edge that updates stable.
  assign rise_ev  = stable_nxt_vec[N_IRQ-1:0] & ~stable_vec[N_IRQ-1:0];
  assign fall_ev  = ~stable_nxt_vec[N_IRQ-1:0] & stable_vec[N_IRQ-1:0];
  assign set_ev   = (rise_ev & rise_en_q) | (fall_ev & fall_en_q);
  assign w1c_bits = (wr_en && reg_addr == CAPE_IRQ_STATUS) ?
                    APB_SLAVE_SLAVE_PWDATA[N_IRQ-1:0] : '0;

  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    deb_en_d  = deb_en_q;
    mask_d    = mask_q;
    deb_div_d = deb_div_q;
    presc_d   = tick ? 16'd0 : presc_q + 16'd1;
    status_d  = (status_q & ~w1c_bits) | set_ev;
    if (wr_en) begin
      case (reg_addr)
        CAPE_IRQ_RISE_EN: rise_en_d = APB_SLAVE_SLAVE_PWDATA[N_IRQ-1:0];
        CAPE_IRQ_FALL_EN: fall_en_d = APB_SLAVE_SLAVE_PWDATA[N_IRQ-1:0];
        CAPE_IRQ_DEB_EN:  deb_en_d  = APB_SLAVE_SLAVE_PWDATA[N_IN-1:0];
        CAPE_IRQ_MASK:    mask_d    = APB_SLAVE_SLAVE_PWDATA[N_IRQ-1:0];
        CAPE_IRQ_DEB_DIV: begin
          deb_div_d = APB_SLAVE_SLAVE_PWDATA[15:0];
          presc_d   = 16'd0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
      deb_en_q  <= '0;
      status_q  <= '0;
      mask_q    <= '0;
      deb_div_q <= DEB_DIV_RST;
      presc_q   <= 16'd0;
    end else begin
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      deb_en_q  <= deb_en_d;
      status_q  <= status_d;
      mask_q    <= mask_d;
      deb_div_q <= deb_div_d;
      presc_q   <= presc_d;
    end
  end

  always_comb begin
    APB_SLAVE_SLAVE_PRDATA = 32'd0;
    if (APB_SLAVE_SLAVE_PSEL && !APB_SLAVE_SLAVE_PWRITE) begin
      case (reg_addr)
        CAPE_IRQ_IN:      APB_SLAVE_SLAVE_PRDATA = {4'd0, stable_vec};
        CAPE_IRQ_RISE_EN: APB_SLAVE_SLAVE_PRDATA = {8'd0, rise_en_q};
        CAPE_IRQ_FALL_EN: APB_SLAVE_SLAVE_PRDATA = {8'd0, fall_en_q};
        CAPE_IRQ_DEB_EN:  APB_SLAVE_SLAVE_PRDATA = {4'd0, deb_en_q};
        CAPE_IRQ_STATUS:  APB_SLAVE_SLAVE_PRDATA = {8'd0, status_q};
        CAPE_IRQ_MASK:    APB_SLAVE_SLAVE_PRDATA = {8'd0, mask_q};
        CAPE_IRQ_DEB_DIV: APB_SLAVE_SLAVE_PRDATA = {16'd0, deb_div_q};
        default:          APB_SLAVE_SLAVE_PRDATA = 32'd0;
      endcase
    end
  end

  assign {INT_C, INT_B, INT_A} = status_q & mask_q;

endmodule

// File: tb/tb_cape_gpio_irq.sv
// Scoreboard bench for cape_gpio_irq: stimulus tasks push expected APB read
// data and interrupt levels; a negedge monitor pops and compares them.
module tb_cape_gpio_irq;
  import cape_gpio_irq_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESETN;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic [27:0] gpio;
  logic [7:0]  int_a, int_b, int_c;

  cape_gpio_irq dut (
    .PCLK                   (PCLK),
    .PRESETN                (PRESETN),
    .APB_SLAVE_SLAVE_PSEL   (psel),
    .APB_SLAVE_SLAVE_PENABLE(penable),
    .APB_SLAVE_SLAVE_PWRITE (pwrite),
    .APB_SLAVE_SLAVE_PADDR  (paddr),
    .APB_SLAVE_SLAVE_PWDATA (pwdata),
    .APB_SLAVE_SLAVE_PRDATA (prdata),
    .GPIO_IN                (gpio),
    .INT_A                  (int_a),
    .INT_B                  (int_b),
    .INT_C                  (int_c)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    bit          is_int;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur;
  logic [31:0] act;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        int_chk  = 1'b0;

  // Reference model state: what each register should hold
  logic [23:0] m_rise, m_fall, m_mask, m_status;
  logic [27:0] m_in;

  localparam logic [27:0] BIT17 = 28'h002_0000;

  always @(negedge PCLK) begin
    if ((psel && penable && !pwrite) || int_chk) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("[TB] FAIL scoreboard_empty: DUT output with no expected entry");
      end else begin
        cur = sb_q.pop_front();
        act = cur.is_int ? {8'h00, int_c, int_b, int_a} : prdata;
        if (act === cur.exp) n_pass++;
        else $display("[TB] FAIL %s: got %h expected %h", cur.name, act, cur.exp);
      end
    end
  end

  task automatic apbWrite(input logic [7:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic checkOutput(input logic [7:0] a, input logic [31:0] exp, input string name);
    sb_q.push_back('{1'b0, exp, name});
    @(posedge PCLK); #1;
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic checkInt(input logic [23:0] exp, input string name);
    sb_q.push_back('{1'b1, {8'h00, exp}, name});
    int_chk = 1'b1;
    @(negedge PCLK); #1;
    int_chk = 1'b0;
  endtask

  task automatic applyStimulus(input logic [27:0] val, input int settle);
    gpio = val;
    repeat (settle) @(posedge PCLK);
    #1;
  endtask

  // Undebounced pins: a level change is one edge, filtered by the enables
  function automatic void modelEdges(input logic [27:0] nv);
    logic [27:0] r, f;
    r = nv & ~m_in;
    f = ~nv & m_in;
    m_status = m_status | (r[23:0] & m_rise) | (f[23:0] & m_fall);
    m_in = nv;
  endfunction

  task automatic summary();
    $display("%0d/%0d checks passed", n_pass, n_checks);
  endtask

  initial begin
    #400000;
    n_checks++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

  initial begin
    logic [27:0] nv;
    logic [23:0] w;
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; gpio = '0;
    PRESETN = 1'b0;
    m_rise = 0; m_fall = 0; m_mask = 0; m_status = 0; m_in = 0;
    repeat (3) @(posedge PCLK);
    #2 PRESETN = 1'b1;
    $display("[TB] reset values");
    checkOutput(CAPE_IRQ_IN,      32'h0, "rst_in");
    checkOutput(CAPE_IRQ_RISE_EN, 32'h0, "rst_rise_en");
    checkOutput(CAPE_IRQ_FALL_EN, 32'h0, "rst_fall_en");
    checkOutput(CAPE_IRQ_DEB_EN,  32'h0, "rst_deb_en");
    checkOutput(CAPE_IRQ_STATUS,  32'h0, "rst_status");
    checkOutput(CAPE_IRQ_MASK,    32'h0, "rst_mask");
    checkOutput(CAPE_IRQ_DEB_DIV, 32'd1000, "rst_deb_div");
    checkOutput(8'h1C,            32'h0, "unmapped_read");
    checkInt(24'h0, "rst_int");

    $display("[TB] rising edge latency and W1C");
    apbWrite(CAPE_IRQ_RISE_EN, 32'h20); m_rise = 24'h20;
    apbWrite(CAPE_IRQ_MASK,    32'h20); m_mask = 24'h20;
    gpio = 28'h20;
    @(posedge PCLK);
    @(posedge PCLK); #1;
    checkInt(24'h0, "latency_early");
    @(posedge PCLK); #1;
    modelEdges(28'h20);
    checkInt(m_status & m_mask, "latency_k2");
    checkOutput(CAPE_IRQ_STATUS, {8'h0, m_status}, "status_bit5");
    apbWrite(CAPE_IRQ_STATUS, 32'h20); m_status = m_status & ~24'h20;
    checkInt(m_status & m_mask, "w1c_int_low");

    $display("[TB] W1C against a simultaneous edge");
    apbWrite(CAPE_IRQ_RISE_EN, 32'h28); m_rise = 24'h28;
    applyStimulus(gpio | 28'h8, 4); modelEdges(gpio);
    checkOutput(CAPE_IRQ_STATUS, {8'h0, m_status}, "status_bit3");
    applyStimulus(gpio & ~28'h8, 4); modelEdges(gpio);
    gpio = gpio | 28'h8;
    apbWrite(CAPE_IRQ_STATUS, 32'h8);
    modelEdges(gpio);
    checkOutput(CAPE_IRQ_STATUS, {8'h0, m_status}, "w1c_vs_set");
    apbWrite(CAPE_IRQ_STATUS, 32'h8); m_status = m_status & ~24'h8;
    checkOutput(CAPE_IRQ_STATUS, {8'h0, m_status}, "w1c_clear");

    $display("[TB] mask gating");
    apbWrite(CAPE_IRQ_MASK, 32'h0); m_mask = 24'h0;
    apbWrite(CAPE_IRQ_RISE_EN, 32'h228); m_rise = 24'h228;
    applyStimulus(gpio | 28'h200, 4); modelEdges(gpio);
    checkOutput(CAPE_IRQ_STATUS, {8'h0, m_status}, "status_bit9");
    checkInt(m_status & m_mask, "masked_int");
    apbWrite(CAPE_IRQ_MASK, 32'h200); m_mask = 24'h200;
    checkInt(m_status & m_mask, "unmasked_int");

    $display("[TB] IN-only pin");
    applyStimulus(gpio ^ 28'h400_0000, 4); modelEdges(gpio);
    checkOutput(CAPE_IRQ_IN, {4'h0, m_in}, "in_bit26");
    checkOutput(CAPE_IRQ_STATUS, {8'h0, m_status}, "status_bit26");
    checkInt(m_status & m_mask, "int_bit26");

    $display("[TB] randomized edges");
    for (int it = 0; it < 16; it++) begin
      m_rise = 24'($urandom); m_fall = 24'($urandom); m_mask = 24'($urandom);
      apbWrite(CAPE_IRQ_RISE_EN, {8'h0, m_rise});
      apbWrite(CAPE_IRQ_FALL_EN, {8'h0, m_fall});
      apbWrite(CAPE_IRQ_MASK,    {8'h0, m_mask});
      nv = 28'($urandom);
      applyStimulus(nv, 4); modelEdges(nv);
      if ($urandom_range(0, 1) == 1) begin
        w = 24'($urandom);
        apbWrite(CAPE_IRQ_STATUS, {8'h0, w});
        m_status = m_status & ~w;
      end
      checkOutput(CAPE_IRQ_IN, {4'h0, m_in}, "rand_in");
      checkOutput(CAPE_IRQ_STATUS, {8'h0, m_status}, "rand_status");
      checkInt(m_status & m_mask, "rand_int");
    end

    $display("[TB] debounced falling edge");
    apbWrite(CAPE_IRQ_RISE_EN, 32'h0);        m_rise = 24'h0;
    apbWrite(CAPE_IRQ_FALL_EN, {4'h0, BIT17}); m_fall = BIT17[23:0];
    apbWrite(CAPE_IRQ_MASK,    {4'h0, BIT17}); m_mask = BIT17[23:0];
    apbWrite(CAPE_IRQ_STATUS,  32'hFF_FFFF);  m_status = 24'h0;
    applyStimulus(gpio | BIT17, 5); modelEdges(gpio);
    apbWrite(CAPE_IRQ_DEB_DIV, 32'd4);
    checkOutput(CAPE_IRQ_DEB_DIV, 32'd4, "deb_div_rd");
    apbWrite(CAPE_IRQ_DEB_EN, {4'h0, BIT17});
    // 6 low cycles spans at most two ticks; three are needed to commit
    applyStimulus(gpio & ~BIT17, 6);
    applyStimulus(gpio | BIT17, 20);
    checkOutput(CAPE_IRQ_STATUS, {8'h0, m_status}, "glitch_status");
    checkOutput(CAPE_IRQ_IN, {4'h0, m_in}, "glitch_in");
    applyStimulus(gpio & ~BIT17, 40); modelEdges(gpio);
    checkOutput(CAPE_IRQ_STATUS, {8'h0, m_status}, "deb_status");
    checkInt(m_status & m_mask, "deb_int_c");

    $display("[TB] asynchronous reset");
    @(posedge PCLK); #2;
    PRESETN = 1'b0;
    checkInt(24'h0, "async_rst_int");
    @(posedge PCLK); #2;
    PRESETN = 1'b1;
    checkOutput(CAPE_IRQ_STATUS, 32'h0, "post_rst_status");
    checkOutput(CAPE_IRQ_DEB_DIV, 32'd1000, "post_rst_deb_div");

    if (sb_q.size() != 0) begin
      n_checks++;
      $display("[TB] FAIL leftover_entries: got %0d expected 0", sb_q.size());
    end
    summary();
    $finish;
  end

endmodule
